// File: rtl/store_fwd_unit_pkg.sv
// Shared opcodes, forwarding-source encoding and helpers for the store forwarding unit.
package store_fwd_unit_pkg;

    localparam logic [6:0] OP_STYPE = 7'b0100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;

    typedef enum logic [1:0] {
        SEL_RF   = 2'd0,
        SEL_WB   = 2'd1,
        SEL_HIST = 2'd2
    } din_sel_e;

    // Loads and stores in MEM both need the rs2 value forwarded.
    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == OP_STYPE) || (op == OP_LOAD);
    endfunction

endpackage

// File: rtl/store_fwd_unit_if.sv
// Bundle of WB/MEM/hazard-detection fields and store-data outputs of store_fwd_unit.
// FWD_PERF_EN adds the fwd_count output.
interface store_fwd_unit_if #(
    parameter int XLEN = 32
);
    logic            stall_MEM;
    logic            RF_write_WB;
    logic [4:0]      write_addr;
    logic [XLEN-1:0] wb_data;
    logic [6:0]      opcode_MEM;
    logic [4:0]      Read_addr_2_MEM;
    logic [XLEN-1:0] rs2_data_MEM;
    logic [6:0]      opcode_EX;
    logic [4:0]      rd_EX;
    logic [4:0]      rs1_ID;
    logic [4:0]      rs2_ID;
    logic [6:0]      opcode_ID;
    logic [XLEN-1:0] D_in;
    logic [1:0]      D_in_sel;
    logic            load_use_stall;
`ifdef FWD_PERF_EN
    logic [31:0]     fwd_count;
`endif

    modport master (
        output stall_MEM, RF_write_WB, write_addr, wb_data,
        output opcode_MEM, Read_addr_2_MEM, rs2_data_MEM,
        output opcode_EX, rd_EX, rs1_ID, rs2_ID, opcode_ID,
`ifdef FWD_PERF_EN
        input  fwd_count,
`endif
        input  D_in, D_in_sel, load_use_stall
    );

    modport slave (
        input  stall_MEM, RF_write_WB, write_addr, wb_data,
        input  opcode_MEM, Read_addr_2_MEM, rs2_data_MEM,
        input  opcode_EX, rd_EX, rs1_ID, rs2_ID, opcode_ID,
`ifdef FWD_PERF_EN
        output fwd_count,
`endif
        output D_in, D_in_sel, load_use_stall
    );

endinterface

// File: rtl/store_fwd_unit_fwd_hist_buf.sv
// Writeback history captured while MEM is frozen: shift-in at hist[0], bulk clear,
// newest-first lookup by register index.
module fwd_hist_buf
    import store_fwd_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            push,
    input  logic [4:0]      push_addr,
    input  logic [XLEN-1:0] push_data,
    input  logic [4:0]      lookup_addr,
    output logic            hit,
    output logic [XLEN-1:0] hit_data
);

    logic [DEPTH-1:0] vld;
    logic [4:0]       addr [DEPTH];
    logic [XLEN-1:0]  data [DEPTH];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            vld <= '0;
        end else if (push) begin
            for (int i = DEPTH - 1; i > 0; i--) vld[i] <= vld[i-1];
            vld[0] <= 1'b1;
        end
    end

    // Payload carries no reset; validity alone decides whether an entry is used.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                addr[i] <= addr[i-1];
                data[i] <= data[i-1];
            end
            addr[0] <= push_addr;
            data[0] <= push_data;
        end
    end

    // Scan oldest to newest so the newest matching entry wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (vld[i] && (addr[i] == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = data[i];
            end
        end
    end

endmodule

// File: rtl/store_fwd_unit.sv
// Store-data forwarding (live WB, then stall-time WB history) plus load-use stall FSM.
// FWD_PERF_EN adds a 32-bit forwarding-event counter.
module store_fwd_unit
    import store_fwd_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    store_fwd_unit_if.slave  bus
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] BUBBLE = 1'b1;

    logic            fwd_en;
    logic            live_hit;
    logic            hist_push;
    logic            hist_hit;
    logic [XLEN-1:0] hist_data;
    din_sel_e        sel;
    logic [XLEN-1:0] din;
    logic            lu_hazard;
    logic [0:0]      state;
    logic [0:0]      state_nxt;

    assign fwd_en    = is_mem_op(bus.opcode_MEM) && (bus.Read_addr_2_MEM != 5'd0);
    assign live_hit  = bus.RF_write_WB && (bus.write_addr == bus.Read_addr_2_MEM);
    assign hist_push = bus.stall_MEM && bus.RF_write_WB && (bus.write_addr != 5'd0);

    fwd_hist_buf #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_hist (
        .clk         (clk),
        .rst         (rst),
        .clr         (!bus.stall_MEM),
        .push        (hist_push),
        .push_addr   (bus.write_addr),
        .push_data   (bus.wb_data),
        .lookup_addr (bus.Read_addr_2_MEM),
        .hit         (hist_hit),
        .hit_data    (hist_data)
    );

    always_comb begin
        sel = SEL_RF;
        din = bus.rs2_data_MEM;
        if (fwd_en && live_hit) begin
            sel = SEL_WB;
            din = bus.wb_data;
        end else if (fwd_en && hist_hit) begin
            sel = SEL_HIST;
            din = hist_data;
        end
    end

    assign bus.D_in     = din;
    assign bus.D_in_sel = sel;

    // A store's rs2 is covered by MEM forwarding, so only its rs1 can cause a load-use stall.
    assign lu_hazard = (bus.opcode_EX == OP_LOAD) && (bus.rd_EX != 5'd0) &&
                       ((bus.rd_EX == bus.rs1_ID) ||
                        ((bus.rd_EX == bus.rs2_ID) && (bus.opcode_ID != OP_STYPE)));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (lu_hazard)      state_nxt = BUBBLE;
            BUBBLE:  if (!bus.stall_MEM) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    assign bus.load_use_stall = (state == IDLE) && lu_hazard;

`ifdef FWD_PERF_EN
    logic [31:0] fwd_count;

    always_ff @(posedge clk) begin
        if (rst)                                fwd_count <= '0;
        else if (sel != SEL_RF && !bus.stall_MEM) fwd_count <= fwd_count + 32'd1;
    end

    assign bus.fwd_count = fwd_count;
`endif

endmodule

// File: tb/tb_store_fwd_unit.sv
// Scoreboard bench for store_fwd_unit: expectations queued with each stimulus cycle.
module tb_store_fwd_unit;
    import store_fwd_unit_pkg::*;

    localparam logic [6:0] OP_ADD = 7'b0110011;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    typedef struct {
        string       tag;
        logic [31:0] d;
        logic [1:0]  sel;
        logic        lus;
    } exp_t;

    exp_t exp_q[$];

    store_fwd_unit_if #(.XLEN(32)) bus ();

    store_fwd_unit #(.XLEN(32), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, need $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, need 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [31:0] d,
                              input logic [1:0] sel, input logic lus);
        exp_t e;
        e.tag = tag; e.d = d; e.sel = sel; e.lus = lus;
        exp_q.push_back(e);
    endtask

    // Compare queued expectations mid-cycle, then advance past the next rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({e.tag, ".D_in"}, bus.D_in, e.d);
            chk({e.tag, ".sel"}, {30'd0, bus.D_in_sel}, {30'd0, e.sel});
            chk({e.tag, ".lus"}, {31'd0, bus.load_use_stall}, {31'd0, e.lus});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        rst                 = 1'b0;
        bus.stall_MEM       = 1'b0;
        bus.RF_write_WB     = 1'b0;
        bus.write_addr      = 5'd0;
        bus.wb_data         = '0;
        bus.opcode_MEM      = 7'd0;
        bus.Read_addr_2_MEM = 5'd0;
        bus.rs2_data_MEM    = 32'h0000_1234;
        bus.opcode_EX       = OP_ADD;
        bus.rd_EX           = 5'd0;
        bus.rs1_ID          = 5'd0;
        bus.rs2_ID          = 5'd0;
        bus.opcode_ID       = OP_ADD;
    endtask

    task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
        bus.RF_write_WB = en;
        bus.write_addr  = a;
        bus.wb_data     = d;
    endtask

    task automatic mem(input logic [6:0] op, input logic [4:0] rs2, input logic [31:0] v);
        bus.opcode_MEM      = op;
        bus.Read_addr_2_MEM = rs2;
        bus.rs2_data_MEM    = v;
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset asserted mid-stall: outputs still see live WB, capture suppressed.
        rst = 1'b1; bus.stall_MEM = 1'b1;
        wb(1, 5'd5, 32'h77); mem(OP_STYPE, 5'd5, 32'hA);
        expect_out("rst_live", 32'h77, 2'd1, 1'b0);
        tick();
        rst = 1'b0; wb(0, 5'd0, 32'h0);
        expect_out("rst_nohist", 32'hA, 2'd0, 1'b0);
`ifdef FWD_PERF_EN
        chk("cnt_rst", bus.fwd_count, 32'd0);
`endif
        tick();

        // Live WB forwarding and the x0 / non-memory-op exclusions.
        bus.stall_MEM = 1'b0;
        wb(1, 5'd5, 32'hDEADBEEF); mem(OP_STYPE, 5'd5, 32'h1);
        expect_out("sw_live", 32'hDEADBEEF, 2'd1, 1'b0);
        tick();
        wb(1, 5'd5, 32'hCAFE); mem(OP_LOAD, 5'd5, 32'h2);
        expect_out("lw_live", 32'hCAFE, 2'd1, 1'b0);
        tick();
        wb(1, 5'd0, 32'hFF); mem(OP_STYPE, 5'd0, 32'h3);
        expect_out("x0", 32'h3, 2'd0, 1'b0);
        tick();
        wb(1, 5'd5, 32'hFF); mem(OP_ADD, 5'd5, 32'h4);
        expect_out("non_mem", 32'h4, 2'd0, 1'b0);
        tick();

        // Stall with one WB write, then history supplies it until MEM advances.
        bus.stall_MEM = 1'b1;
        wb(1, 5'd5, 32'h11); mem(OP_STYPE, 5'd5, 32'h5);
        expect_out("stall_c1", 32'h11, 2'd1, 1'b0);
        tick();
        wb(0, 5'd0, 32'h0);
        expect_out("stall_c2", 32'h11, 2'd2, 1'b0);
        tick();
        expect_out("stall_c3", 32'h11, 2'd2, 1'b0);
        tick();
        bus.stall_MEM = 1'b0; wb(1, 5'd5, 32'h99);
        expect_out("adv_live", 32'h99, 2'd1, 1'b0);
        tick();
        wb(0, 5'd0, 32'h0);
        expect_out("adv_clear", 32'h5, 2'd0, 1'b0);
        tick();

        // DEPTH=2 overflow and newest-duplicate priority.
        bus.stall_MEM = 1'b1; mem(OP_STYPE, 5'd6, 32'h6);
        wb(1, 5'd6, 32'h1);
        expect_out("d_x6a", 32'h1, 2'd1, 1'b0);
        tick();
        wb(1, 5'd6, 32'h2);
        expect_out("d_x6b", 32'h2, 2'd1, 1'b0);
        tick();
        wb(1, 5'd7, 32'h3);
        expect_out("d_x6_hist", 32'h2, 2'd2, 1'b0);
        tick();
        wb(0, 5'd0, 32'h0);
        expect_out("d_x6_new", 32'h2, 2'd2, 1'b0);
        tick();
        mem(OP_STYPE, 5'd7, 32'h7);
        expect_out("d_x7", 32'h3, 2'd2, 1'b0);
        tick();
        wb(1, 5'd8, 32'h4); mem(OP_STYPE, 5'd6, 32'h6);
        expect_out("d_x6_pre", 32'h2, 2'd2, 1'b0);
        tick();
        wb(0, 5'd0, 32'h0);
        expect_out("d_x6_drop", 32'h6, 2'd0, 1'b0);
        tick();
        wb(1, 5'd7, 32'h55); mem(OP_STYPE, 5'd7, 32'h7);
        expect_out("d_live_pri", 32'h55, 2'd1, 1'b0);
        tick();

        // Reset during stall with full history.
        rst = 1'b1; wb(0, 5'd0, 32'h0);
        expect_out("r_full_pre", 32'h55, 2'd2, 1'b0);
        tick();
        rst = 1'b0; mem(OP_STYPE, 5'd8, 32'h88);
        expect_out("r_full_post", 32'h88, 2'd0, 1'b0);
`ifdef FWD_PERF_EN
        chk("cnt_rst2", bus.fwd_count, 32'd0);
`endif
        tick();

        // Load-use FSM.
        set_idle();
        bus.opcode_EX = OP_LOAD; bus.rd_EX = 5'd3; bus.rs1_ID = 5'd3;
        expect_out("lu_hit", 32'h1234, 2'd0, 1'b1);
        tick();
        expect_out("lu_bubble", 32'h1234, 2'd0, 1'b0);
        tick();
        bus.rs1_ID = 5'd1;
        expect_out("lu_idle", 32'h1234, 2'd0, 1'b0);
        tick();
        bus.rs2_ID = 5'd3; bus.opcode_ID = OP_STYPE;
        expect_out("lu_sw_rs2", 32'h1234, 2'd0, 1'b0);
        tick();
        bus.opcode_ID = OP_ADD;
        expect_out("lu_rs2", 32'h1234, 2'd0, 1'b1);
        tick();
        bus.stall_MEM = 1'b1;
        expect_out("lu_hold1", 32'h1234, 2'd0, 1'b0);
        tick();
        bus.stall_MEM = 1'b0;
        expect_out("lu_hold2", 32'h1234, 2'd0, 1'b0);
        tick();
        expect_out("lu_again", 32'h1234, 2'd0, 1'b1);
        tick();
        rst = 1'b1;
        expect_out("lu_rst_pre", 32'h1234, 2'd0, 1'b0);
        tick();
        rst = 1'b0; bus.rd_EX = 5'd0; bus.rs2_ID = 5'd0; bus.rs1_ID = 5'd0;
        expect_out("lu_rd0", 32'h1234, 2'd0, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
